// File: rtl/display_pkg.sv
// Shared types and constants for the result display stage: FSM states,
// flag payload, seven-segment codes and the BCD adjust helper.
package display_pkg;

  localparam int unsigned VAL_W   = 8;
  localparam int unsigned NUM_BCD = 3;
  localparam int unsigned SHIFTS  = 8;
  localparam int unsigned BCD_W   = 4 * NUM_BCD;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned SEG_W   = 7;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    UPDATE
  } state_e;

  typedef struct packed {
    logic cout;
    logic overflow;
    logic zero;
  } flags_t;

  // Active-low codes, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_MINUS = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  function automatic logic [SEG_W-1:0] seg_polarity(input logic [SEG_W-1:0] seg,
                                                    input bit active_low);
    return active_low ? seg : ~seg;
  endfunction

  // Add 3 to every nibble >= 5 ahead of the double-dabble shift
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int unsigned i = 0; i < NUM_BCD; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return res;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD digit to seven-segment encoder with blank input.
module seg7_encode
  import display_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0]       digit_i,
  input  logic             blank_i,
  output logic [SEG_W-1:0] seg_c
);

  logic [SEG_W-1:0] seg_raw;

  always_comb begin
    seg_raw = SEG_BLANK;
    if (!blank_i && (digit_i <= 4'd9)) seg_raw = SEG_DIGIT[digit_i];
    seg_c = seg_polarity(seg_raw, SEG_ACTIVE_LOW);
  end

endmodule

// File: rtl/result_display.sv
// Result display: double-dabble conversion of the calculator result onto four
// seven-segment digits plus flag LEDs. SIGNED_DISPLAY_EN enables two's complement.
module result_display
  import display_pkg::*;
#(
  parameter bit LEAD_ZERO_BLANK = 1'b1,
  parameter bit SEG_ACTIVE_LOW  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [VAL_W-1:0] value,
  input  logic             zero_in,
  input  logic             overflow_in,
  input  logic             cout_in,
  output logic             busy,
  output logic [SEG_W-1:0] hex0,
  output logic [SEG_W-1:0] hex1,
  output logic [SEG_W-1:0] hex2,
  output logic [SEG_W-1:0] hex3,
  output logic [2:0]       led_flags
);

  localparam logic [SEG_W-1:0] BLANK_OUT = SEG_ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;
  localparam logic [SEG_W-1:0] MINUS_OUT = SEG_ACTIVE_LOW ? SEG_MINUS : ~SEG_MINUS;

  state_e           state_q, state_d;
  logic [VAL_W-1:0] shreg_q, shreg_d;
  logic [BCD_W-1:0] bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  flags_t           flags_q, flags_d;
  logic             busy_q, busy_d;
  logic [SEG_W-1:0] hex0_q, hex0_d, hex1_q, hex1_d, hex2_q, hex2_d, hex3_q, hex3_d;
  logic [2:0]       led_q, led_d;
  logic [VAL_W-1:0] mag;
  logic [SEG_W-1:0] seg0_c, seg1_c, seg2_c;
  logic             blank1, blank2;
`ifdef SIGNED_DISPLAY_EN
  logic             neg_q, neg_d;
`endif

  // Leading-zero blanking from the final BCD digits
  assign blank2 = LEAD_ZERO_BLANK && (bcd_q[11:8] == 4'd0);
  assign blank1 = blank2 && (bcd_q[7:4] == 4'd0);

  seg7_encode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg0 (
    .digit_i(bcd_q[3:0]), .blank_i(1'b0), .seg_c(seg0_c));
  seg7_encode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg1 (
    .digit_i(bcd_q[7:4]), .blank_i(blank1), .seg_c(seg1_c));
  seg7_encode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg2 (
    .digit_i(bcd_q[11:8]), .blank_i(blank2), .seg_c(seg2_c));

`ifdef SIGNED_DISPLAY_EN
  assign mag = value[VAL_W-1] ? VAL_W'(~value + VAL_W'(1)) : value;
`else
  assign mag = value;
`endif

  assign bcd_adj = bcd_adjust(bcd_q);

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    flags_d = flags_q;
    hex0_d  = hex0_q;
    hex1_d  = hex1_q;
    hex2_d  = hex2_q;
    hex3_d  = hex3_q;
    led_d   = led_q;
`ifdef SIGNED_DISPLAY_EN
    neg_d   = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (load) begin
          shreg_d = mag;
          bcd_d   = '0;
          cnt_d   = '0;
          flags_d = '{cout: cout_in, overflow: overflow_in, zero: zero_in};
`ifdef SIGNED_DISPLAY_EN
          neg_d   = value[VAL_W-1];
`endif
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        {bcd_d, shreg_d} = {bcd_adj[BCD_W-2:0], shreg_q, 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(SHIFTS - 1)) state_d = UPDATE;
      end
      UPDATE: begin
        hex0_d = seg0_c;
        hex1_d = seg1_c;
        hex2_d = seg2_c;
`ifdef SIGNED_DISPLAY_EN
        hex3_d = neg_q ? MINUS_OUT : BLANK_OUT;
`else
        hex3_d = BLANK_OUT;
`endif
        led_d   = flags_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      flags_q <= '0;
      busy_q  <= 1'b0;
      hex0_q  <= BLANK_OUT;
      hex1_q  <= BLANK_OUT;
      hex2_q  <= BLANK_OUT;
      hex3_q  <= BLANK_OUT;
      led_q   <= '0;
`ifdef SIGNED_DISPLAY_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
      busy_q  <= busy_d;
      hex0_q  <= hex0_d;
      hex1_q  <= hex1_d;
      hex2_q  <= hex2_d;
      hex3_q  <= hex3_d;
      led_q   <= led_d;
`ifdef SIGNED_DISPLAY_EN
      neg_q   <= neg_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign hex0      = hex0_q;
  assign hex1      = hex1_q;
  assign hex2      = hex2_q;
  assign hex3      = hex3_q;
  assign led_flags = led_q;

endmodule

// File: tb/tb_result_display.sv
// Bench for result_display: vector table and random values through a scoreboard,
// plus busy-drop and mid-conversion reset sequences.
module tb_result_display;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                         S9 = 7'b0010000, SM = 7'b0111111, SB = 7'b1111111;

  typedef struct {
    logic [6:0] h0, h1, h2, h3;
    logic [2:0] led;
  } exp_t;

  typedef struct {
    logic [7:0] v;
    logic [2:0] flg;  // {cout, overflow, zero}
    exp_t       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset, load, zero_in, overflow_in, cout_in, busy;
  logic [7:0] value;
  logic [6:0] hex0, hex1, hex2, hex3;
  logic [2:0] led_flags;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];
  exp_t shown;

  always #5 clk = ~clk;

  result_display #(.LEAD_ZERO_BLANK(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .load(load), .value(value), .zero_in(zero_in),
    .overflow_in(overflow_in), .cout_in(cout_in), .busy(busy), .hex0(hex0),
    .hex1(hex1), .hex2(hex2), .hex3(hex3), .led_flags(led_flags));

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return S0; 1: return S1; 2: return S2; 3: return S3; 4: return S4;
      5: return S5; 6: return S6; 7: return S7; 8: return S8; 9: return S9;
      default: return SB;
    endcase
  endfunction

  // Arithmetic reference: digits by division rather than shift-add
  function automatic exp_t model(input logic [7:0] v, input logic [2:0] flg);
    exp_t e;
    int mag, h, t, u;
    bit neg;
    mag = int'(v);
    neg = 1'b0;
`ifdef SIGNED_DISPLAY_EN
    if (v[7]) begin
      neg = 1'b1;
      mag = 256 - int'(v);
    end
`endif
    h = mag / 100;
    t = (mag / 10) % 10;
    u = mag % 10;
    e.h0  = seg_of(u);
    e.h1  = (h == 0 && t == 0) ? SB : seg_of(t);
    e.h2  = (h == 0) ? SB : seg_of(h);
    e.h3  = neg ? SM : SB;
    e.led = flg;
    return e;
  endfunction

  task automatic start_load(input logic [7:0] v, input logic [2:0] flg);
    @(negedge clk);
    value = v;
    {cout_in, overflow_in, zero_in} = flg;
    load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
  endtask

  // Wait for busy to fall; outputs must hold the previous display meanwhile
  task automatic wait_done(input int exp_lat);
    int lat = 0;
    while (busy === 1'b1 && lat < 30) begin
      chk("hold_hex0", hex0, shown.h0);
      chk("hold_led", {4'd0, led_flags}, {4'd0, shown.led});
      @(negedge clk);
      lat++;
    end
    chk("latency", 7'(lat), 7'(exp_lat));
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s_sb_empty: got 0 entries want 1", tag);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, "_hex0"}, hex0, e.h0);
    chk({tag, "_hex1"}, hex1, e.h1);
    chk({tag, "_hex2"}, hex2, e.h2);
    chk({tag, "_hex3"}, hex3, e.h3);
    chk({tag, "_led"}, {4'd0, led_flags}, {4'd0, e.led});
    shown = e;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'd0,   3'b001, '{S0, SB, SB, SB, 3'b001}};
`ifdef SIGNED_DISPLAY_EN
    vecs[1] = '{8'd255, 3'b100, '{S1, SB, SB, SM, 3'b100}};
    vecs[3] = '{8'd128, 3'b111, '{S8, S2, S1, SM, 3'b111}};
`else
    vecs[1] = '{8'd255, 3'b100, '{S5, S5, S2, SB, 3'b100}};
    vecs[3] = '{8'd128, 3'b111, '{S8, S2, S1, SB, 3'b111}};
`endif
    vecs[2] = '{8'd105, 3'b010, '{S5, S0, S1, SB, 3'b010}};
    vecs[4] = '{8'd127, 3'b000, '{S7, S2, S1, SB, 3'b000}};
    vecs[5] = '{8'd10,  3'b011, '{S0, S1, SB, SB, 3'b011}};
    vecs[6] = '{8'd100, 3'b101, '{S0, S0, S1, SB, 3'b101}};
    vecs[7] = '{8'd9,   3'b000, '{S9, SB, SB, SB, 3'b000}};

    reset = 1'b1; load = 1'b0; value = '0;
    zero_in = 1'b0; overflow_in = 1'b0; cout_in = 1'b0;
    shown = '{SB, SB, SB, SB, 3'b000};
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_hex0", hex0, SB);
    chk("rst_hex1", hex1, SB);
    chk("rst_hex2", hex2, SB);
    chk("rst_hex3", hex3, SB);
    chk("rst_led", {4'd0, led_flags}, 7'd0);
    chk("rst_busy", {6'd0, busy}, 7'd0);

    foreach (vecs[i]) begin
      sb_q.push_back(vecs[i].e);
      start_load(vecs[i].v, vecs[i].flg);
      wait_done(9);
      pop_check($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 6; i++) begin
      logic [7:0] rv;
      logic [2:0] rf;
      rv = 8'($urandom_range(0, 255));
      rf = 3'($urandom_range(0, 7));
      sb_q.push_back(model(rv, rf));
      start_load(rv, rf);
      wait_done(9);
      pop_check($sformatf("rnd%0d", i));
    end

    // Load arriving at E3 while busy is dropped
    sb_q.push_back('{S7, SB, SB, SB, 3'b000});
    start_load(8'd7, 3'b000);
    @(negedge clk);
    @(negedge clk);
    value = 8'd9;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    wait_done(6);
    pop_check("drop");
    repeat (4) @(negedge clk);
    chk("drop_idle_busy", {6'd0, busy}, 7'd0);
    chk("drop_hold_hex0", hex0, S7);

    // Reset at E4 aborts the conversion and discards its result
    start_load(8'd55, 3'b111);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {6'd0, busy}, 7'd0);
    chk("abort_hex0", hex0, SB);
    chk("abort_hex1", hex1, SB);
    chk("abort_led", {4'd0, led_flags}, 7'd0);
    repeat (12) @(negedge clk);
    chk("abort_late_busy", {6'd0, busy}, 7'd0);
    chk("abort_late_hex0", hex0, SB);
    chk("abort_late_hex1", hex1, SB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
